// File: rtl/systolic_output_collector_pkg.sv
// Shared constants and FSM state encoding for the systolic output collector.
package systolic_output_collector_pkg;

    localparam int DEF_WORDLENGTH  = 16;
    localparam int DEF_OUT_WIDTH   = 12;
    localparam int DEF_SLOT_CYCLES = 30;
    localparam int DEF_TAPS        = 8;
    localparam int DEF_PHASE       = 2;
    localparam int DEF_FIFO_DEPTH  = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/systolic_output_collector_if.sv
// Collector bus: frame start, PE word in, narrowed sample stream out plus status.
interface systolic_output_collector_if #(
    parameter int WORDLENGTH = 16,
    parameter int OUT_WIDTH  = 12
);
    logic                         start;
    logic signed [WORDLENGTH-1:0] inputword;
    logic signed [OUT_WIDTH-1:0]  out_data;
    logic                         out_valid;
    logic                         out_ready;
    logic                         overflow;
    logic                         fifo_full;

    // master: PE/sink side; slave: the collector itself
    modport master (
        output start, inputword, out_ready,
        input  out_data, out_valid, overflow, fifo_full
    );

    modport slave (
        input  start, inputword, out_ready,
        output out_data, out_valid, overflow, fifo_full
    );
endinterface

// File: rtl/systolic_output_collector_fifo.sv
// collector_fifo: small first-word-fall-through FIFO, async active-low reset on control only.
module collector_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        rd_en    = pop && !empty;
        // a full FIFO still accepts a push when the head leaves on the same edge
        wr_en    = push && (!full || rd_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (wr_en && !rd_en) begin
            count_d = count_q + CNT_W'(1);
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/systolic_output_collector.sv
// Frame tracker, capture, narrowing and FIFO buffering behind a systolic PE.
// Build option COLLECTOR_ROUND_EN: round half up and saturate instead of truncating.
module systolic_output_collector
    import systolic_output_collector_pkg::*;
#(
    parameter int WORDLENGTH  = DEF_WORDLENGTH,
    parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
    parameter int SLOT_CYCLES = DEF_SLOT_CYCLES,
    parameter int TAPS        = DEF_TAPS,
    parameter int PHASE       = DEF_PHASE,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                        clk30x,
    input  logic                        reset_n,
    systolic_output_collector_if.slave  bus
);
    localparam int SHIFT  = WORDLENGTH - OUT_WIDTH;
    localparam int CYC_W  = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int SLOT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CYC_W-1:0]  CYC_LAST   = CYC_W'(SLOT_CYCLES - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(TAPS - 1);
    localparam logic [SLOT_W-1:0] SLOT_PHASE = SLOT_W'(PHASE);

`ifdef COLLECTOR_ROUND_EN
    localparam logic signed [WORDLENGTH:0] RND_BIAS = (SHIFT > 0) ? (WORDLENGTH+1)'(2 ** (SHIFT - 1)) : '0;
    localparam logic signed [WORDLENGTH:0] SAT_MAX  = (WORDLENGTH+1)'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [WORDLENGTH:0] SAT_MIN  = -(WORDLENGTH+1)'(2 ** (OUT_WIDTH - 1));

    function automatic logic signed [OUT_WIDTH-1:0] narrow(input logic signed [WORDLENGTH-1:0] w);
        logic signed [WORDLENGTH:0] sum;
        logic signed [WORDLENGTH:0] shr;
        // one guard bit keeps the biased sum exact; only the shifted result can exceed range
        sum = {w[WORDLENGTH-1], w} + RND_BIAS;
        shr = sum >>> SHIFT;
        if (shr > SAT_MAX) begin
            return SAT_MAX[OUT_WIDTH-1:0];
        end else if (shr < SAT_MIN) begin
            return SAT_MIN[OUT_WIDTH-1:0];
        end
        return shr[OUT_WIDTH-1:0];
    endfunction
`else
    function automatic logic signed [OUT_WIDTH-1:0] narrow(input logic signed [WORDLENGTH-1:0] w);
        // taking the top bits is an arithmetic shift right, i.e. truncation toward -inf
        return w[WORDLENGTH-1 -: OUT_WIDTH];
    endfunction
`endif

    state_e              state_q, state_d;
    logic [CYC_W-1:0]    cyc_cnt_q, cyc_cnt_d;
    logic [SLOT_W-1:0]   slot_cnt_q, slot_cnt_d;
    logic                overflow_q, overflow_d;
    logic                capture;
    logic                pop;
    logic                push;
    logic                fifo_full_w;
    logic                fifo_empty;
    logic signed [OUT_WIDTH-1:0] sample;
    logic [OUT_WIDTH-1:0]        fifo_dout;

    assign pop    = !fifo_empty && bus.out_ready;
    assign sample = narrow(bus.inputword);
    assign push   = capture;

    always_comb begin
        state_d    = state_q;
        cyc_cnt_d  = cyc_cnt_q;
        slot_cnt_d = slot_cnt_q;
        overflow_d = overflow_q;
        capture    = 1'b0;
        if (bus.start) begin
            // the start cycle itself is count 0 of slot 0, so the next cycle is count 1
            state_d    = ST_RUN;
            cyc_cnt_d  = CYC_W'(1);
            slot_cnt_d = '0;
            overflow_d = 1'b0;
        end else if (state_q == ST_RUN) begin
            if (cyc_cnt_q == CYC_LAST) begin
                cyc_cnt_d  = '0;
                slot_cnt_d = (slot_cnt_q == SLOT_LAST) ? '0 : slot_cnt_q + SLOT_W'(1);
            end else begin
                cyc_cnt_d  = cyc_cnt_q + CYC_W'(1);
            end
            capture = (cyc_cnt_q == CYC_LAST) && (slot_cnt_q == SLOT_PHASE);
            if (capture && fifo_full_w && !pop) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk30x or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cyc_cnt_q  <= '0;
            slot_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_cnt_q  <= cyc_cnt_d;
            slot_cnt_q <= slot_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // capture edge -> FIFO; head is visible the following cycle
    collector_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk30x),
        .rst_n (reset_n),
        .push  (push),
        .pop   (pop),
        .din   (sample),
        .dout  (fifo_dout),
        .full  (fifo_full_w),
        .empty (fifo_empty)
    );

    assign bus.out_data  = fifo_dout;
    assign bus.out_valid = !fifo_empty;
    assign bus.fifo_full = fifo_full_w;
    assign bus.overflow  = overflow_q;
endmodule
